// File: rtl/alu_seq.sv
// alu_seq: accumulator-based command sequencer in front of a combinational
// 16-bit ALU. Accepts one command at a time over valid/ready, sequences the
// ALU (one pass for ADD/SUB/AND/OR, sixteen shift-add passes for MUL) and
// returns the accumulator, carry and zero flags as a single response.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // Command channel
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    // Response channel
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             busy,
    // ALU operand side
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_o,
    input  logic             alu_cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_RESP
    } state_t;

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_MUL  = 3'b101,
        OP_READ = 3'b110,
        OP_NOP  = 3'b111
    } cmd_op_t;

    // ALU function encodings on alu_op
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    state_t             state;
    cmd_op_t            op_q;     // command currently being executed
    logic [WIDTH-1:0]   acc;
    logic               carry;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   mcand;    // multiplicand, shifted left each pass
    logic [WIDTH-1:0]   mplier;   // multiplier, shifted right each pass
    logic [WIDTH-1:0]   prod;     // running partial product
    logic [CNT_W-1:0]   cnt;

    // Handshake and response fields are decoded purely from registered state,
    // so they cannot glitch on input changes and stay put while backpressured.
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_data  = acc;
    assign rsp_carry = carry;
    assign rsp_zero  = (acc == '0);

    // Drive the ALU operands for the current execution step; idle otherwise.
    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves a value unassigned, which would otherwise infer a latch.
        alu_op = ALU_ADD;
        alu_a  = '0;
        alu_b  = '0;
        unique case (state)
            S_EXEC: begin
                alu_a = acc;
                alu_b = opnd;
                case (op_q)
                    OP_SUB:  alu_op = ALU_SUB;
                    OP_AND:  alu_op = ALU_AND;
                    OP_OR:   alu_op = ALU_OR;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_MUL: begin
                alu_op = ALU_ADD;
                alu_a  = prod;
                alu_b  = mplier[0] ? mcand : '0;
            end
            default: ;
        endcase
    end

    // Sequencer FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every register samples pre-edge values regardless of order.
            state  <= S_IDLE;
            op_q   <= OP_NOP;
            acc    <= '0;
            carry  <= 1'b0;
            opnd   <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q <= cmd_op_t'(cmd_op);
                        opnd <= cmd_data;
                        case (cmd_op_t'(cmd_op))
                            OP_LOAD: begin
                                acc   <= cmd_data;
                                carry <= 1'b0;
                                state <= S_RESP;
                            end
                            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                                state <= S_EXEC;
                            end
                            OP_MUL: begin
                                prod   <= '0;
                                mcand  <= acc;
                                mplier <= cmd_data;
                                cnt    <= '0;
                                carry  <= 1'b0;
                                state  <= S_MUL;
                            end
                            default: begin
                                // READ / NOP: report the accumulator untouched
                                state <= S_RESP;
                            end
                        endcase
                    end
                end

                S_EXEC: begin
                    acc   <= alu_o;
                    // SUB carry is the ALU's "no borrow"; logic ops clear it
                    carry <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? alu_cout : 1'b0;
                    state <= S_RESP;
                end

                S_MUL: begin
                    prod   <= alu_o;
                    // Sticky OR of partial-sum carries, not a full overflow flag
                    carry  <= carry | alu_cout;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        acc   <= alu_o;
                        state <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
